// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: ROB index width, source
// encodings and default per-source FIFO depth.
package cdb_arbiter_pkg;

    localparam int   ROB_BITS       = 4;
    localparam int   CDB_FIFO_DEPTH = 4;
    localparam logic CDB_SRC_ALU    = 1'b0;
    localparam logic CDB_SRC_LSB    = 1'b1;

endpackage

// File: rtl/cdb_fifo.sv
// Small per-source result FIFO ({rob_entry, value}) with synchronous reset and
// flush. A push while full is dropped, and a pop while empty is dropped.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_BITS   = cdb_arbiter_pkg::ROB_BITS,
    parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          push_in,
    input  logic                          pop_in,
    input  logic                          clear_in,
    input  logic [ROB_BITS+31:0]          data_in,
    output logic [ROB_BITS+31:0]          head_out,
    output logic                          empty_out,
    output logic                          full_out,
    output logic [$clog2(FIFO_DEPTH):0]   count_out
);

    localparam int             PTR_W     = $clog2(FIFO_DEPTH);
    localparam int             DATA_W    = ROB_BITS + 32;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign empty_out = (count_q == '0);
    assign full_out  = (count_q == DEPTH_CNT);
    assign head_out  = mem_q[rd_ptr_q];
    assign count_out = count_q;
    assign do_push   = push_in & ~full_out;
    assign do_pop    = pop_in & ~empty_out;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_in;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: picks one of the ALU/LSB results per cycle and broadcasts it registered.
// Defining CDB_LSB_PRIORITY_EN replaces round-robin with fixed LSB-first priority.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_BITS   = cdb_arbiter_pkg::ROB_BITS,
    parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear_in,
    input  logic                alu_valid_in,
    input  logic [ROB_BITS-1:0] alu_rob_entry_in,
    input  logic [31:0]         alu_value_in,
    output logic                alu_stall_out,
    input  logic                lsb_valid_in,
    input  logic [ROB_BITS-1:0] lsb_rob_entry_in,
    input  logic [31:0]         lsb_value_in,
    output logic                lsb_stall_out,
    output logic                cdb_valid_out,
    output logic [ROB_BITS-1:0] cdb_rob_entry_out,
    output logic [31:0]         cdb_value_out,
    output logic                cdb_src_out
);

    localparam int            CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [ROB_BITS+31:0] alu_head, lsb_head, alu_cand, lsb_cand;
    logic                 alu_empty, lsb_empty, alu_full, lsb_full;
    logic [CNT_W-1:0]     alu_count, lsb_count;
    logic                 alu_in_ok, lsb_in_ok, alu_cand_valid, lsb_cand_valid;
    logic                 grant_alu, grant_lsb, active;
    logic                 alu_push, alu_pop, lsb_push, lsb_pop, fifo_clear;

    logic                 cdb_valid_q, cdb_valid_d;
    logic [ROB_BITS-1:0]  cdb_rob_entry_q, cdb_rob_entry_d;
    logic [31:0]          cdb_value_q, cdb_value_d;
    logic                 cdb_src_q, cdb_src_d;

    assign active     = rdy_in & ~clear_in;
    assign fifo_clear = rdy_in & clear_in;

    // A full FIFO is never empty, so a stalled input can never take the bypass path.
    assign alu_in_ok      = alu_valid_in & ~alu_full;
    assign lsb_in_ok      = lsb_valid_in & ~lsb_full;
    assign alu_cand_valid = ~alu_empty | alu_in_ok;
    assign lsb_cand_valid = ~lsb_empty | lsb_in_ok;
    assign alu_cand       = alu_empty ? {alu_rob_entry_in, alu_value_in} : alu_head;
    assign lsb_cand       = lsb_empty ? {lsb_rob_entry_in, lsb_value_in} : lsb_head;

`ifdef CDB_LSB_PRIORITY_EN
    assign grant_lsb = lsb_cand_valid;
    assign grant_alu = alu_cand_valid & ~lsb_cand_valid;
`else
    logic last_grant_q, last_grant_d;

    always_comb begin
        grant_alu = alu_cand_valid;
        grant_lsb = lsb_cand_valid;
        if (alu_cand_valid && lsb_cand_valid) begin
            grant_lsb = (last_grant_q == CDB_SRC_ALU);
            grant_alu = ~grant_lsb;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (rdy_in) begin
            if (clear_in) begin
                last_grant_d = CDB_SRC_LSB;
            end else if (grant_lsb) begin
                last_grant_d = CDB_SRC_LSB;
            end else if (grant_alu) begin
                last_grant_d = CDB_SRC_ALU;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_grant_q <= CDB_SRC_LSB;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign alu_pop  = active & grant_alu & ~alu_empty;
    assign lsb_pop  = active & grant_lsb & ~lsb_empty;
    assign alu_push = active & alu_in_ok & ~(grant_alu & alu_empty);
    assign lsb_push = active & lsb_in_ok & ~(grant_lsb & lsb_empty);

    cdb_fifo #(.ROB_BITS(ROB_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push_in   (alu_push),
        .pop_in    (alu_pop),
        .clear_in  (fifo_clear),
        .data_in   ({alu_rob_entry_in, alu_value_in}),
        .head_out  (alu_head),
        .empty_out (alu_empty),
        .full_out  (alu_full),
        .count_out (alu_count)
    );

    cdb_fifo #(.ROB_BITS(ROB_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push_in   (lsb_push),
        .pop_in    (lsb_pop),
        .clear_in  (fifo_clear),
        .data_in   ({lsb_rob_entry_in, lsb_value_in}),
        .head_out  (lsb_head),
        .empty_out (lsb_empty),
        .full_out  (lsb_full),
        .count_out (lsb_count)
    );

    assign alu_stall_out = (alu_count == DEPTH_CNT);
    assign lsb_stall_out = (lsb_count == DEPTH_CNT);

    // Idle and flush cycles drop only the valid bit; the payload keeps its last value.
    always_comb begin
        cdb_valid_d     = cdb_valid_q;
        cdb_rob_entry_d = cdb_rob_entry_q;
        cdb_value_d     = cdb_value_q;
        cdb_src_d       = cdb_src_q;
        if (rdy_in) begin
            if (clear_in) begin
                cdb_valid_d = 1'b0;
            end else begin
                cdb_valid_d = grant_alu | grant_lsb;
                if (grant_lsb) begin
                    {cdb_rob_entry_d, cdb_value_d} = lsb_cand;
                    cdb_src_d                      = CDB_SRC_LSB;
                end else if (grant_alu) begin
                    {cdb_rob_entry_d, cdb_value_d} = alu_cand;
                    cdb_src_d                      = CDB_SRC_ALU;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cdb_valid_q     <= 1'b0;
            cdb_rob_entry_q <= '0;
            cdb_value_q     <= '0;
            cdb_src_q       <= 1'b0;
        end else begin
            cdb_valid_q     <= cdb_valid_d;
            cdb_rob_entry_q <= cdb_rob_entry_d;
            cdb_value_q     <= cdb_value_d;
            cdb_src_q       <= cdb_src_d;
        end
    end

    assign cdb_valid_out     = cdb_valid_q;
    assign cdb_rob_entry_out = cdb_rob_entry_q;
    assign cdb_value_out     = cdb_value_q;
    assign cdb_src_out       = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the arbitration rules.
module tb_cdb_arbiter;

    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        alu_valid_in, lsb_valid_in;
    logic [3:0]  alu_rob_entry_in, lsb_rob_entry_in;
    logic [31:0] alu_value_in, lsb_value_in;
    logic        alu_stall_out, lsb_stall_out;
    logic        cdb_valid_out, cdb_src_out;
    logic [3:0]  cdb_rob_entry_out;
    logic [31:0] cdb_value_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [35:0] m_alu[$];
    logic [35:0] m_lsb[$];
    logic        m_last;
    logic        exp_valid, exp_src;
    logic [3:0]  exp_rob;
    logic [31:0] exp_value;
    logic        saw_lsb_stall;

    always #5 clk_in = ~clk_in;

    cdb_arbiter dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .clear_in          (clear_in),
        .alu_valid_in      (alu_valid_in),
        .alu_rob_entry_in  (alu_rob_entry_in),
        .alu_value_in      (alu_value_in),
        .alu_stall_out     (alu_stall_out),
        .lsb_valid_in      (lsb_valid_in),
        .lsb_rob_entry_in  (lsb_rob_entry_in),
        .lsb_value_in      (lsb_value_in),
        .lsb_stall_out     (lsb_stall_out),
        .cdb_valid_out     (cdb_valid_out),
        .cdb_rob_entry_out (cdb_rob_entry_out),
        .cdb_value_out     (cdb_value_out),
        .cdb_src_out       (cdb_src_out)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: one step of the bus, evaluated on the inputs present before the edge.
    task automatic modelStep();
        logic        alu_ok, lsb_ok, have_a, have_l, pick_a, pick_l;
        logic [35:0] w;
        if (rst_in) begin
            m_alu.delete();
            m_lsb.delete();
            m_last    = 1'b1;
            exp_valid = 1'b0;
            exp_rob   = '0;
            exp_value = '0;
            exp_src   = 1'b0;
        end else if (rdy_in) begin
            if (clear_in) begin
                m_alu.delete();
                m_lsb.delete();
                m_last    = 1'b1;
                exp_valid = 1'b0;
            end else begin
                alu_ok = alu_valid_in && (m_alu.size() < DEPTH);
                lsb_ok = lsb_valid_in && (m_lsb.size() < DEPTH);
                have_a = (m_alu.size() > 0) || alu_ok;
                have_l = (m_lsb.size() > 0) || lsb_ok;
`ifdef CDB_LSB_PRIORITY_EN
                pick_l = have_l;
`else
                pick_l = have_l && (!have_a || m_last == 1'b0);
`endif
                pick_a = have_a && !pick_l;
                exp_valid = have_a || have_l;
                if (pick_a) begin
                    if (m_alu.size() > 0) begin
                        w = m_alu.pop_front();
                        if (alu_ok) m_alu.push_back({alu_rob_entry_in, alu_value_in});
                    end else begin
                        w = {alu_rob_entry_in, alu_value_in};
                    end
                    {exp_rob, exp_value} = w;
                    exp_src = 1'b0;
                    m_last  = 1'b0;
                end else if (alu_ok) begin
                    m_alu.push_back({alu_rob_entry_in, alu_value_in});
                end
                if (pick_l) begin
                    if (m_lsb.size() > 0) begin
                        w = m_lsb.pop_front();
                        if (lsb_ok) m_lsb.push_back({lsb_rob_entry_in, lsb_value_in});
                    end else begin
                        w = {lsb_rob_entry_in, lsb_value_in};
                    end
                    {exp_rob, exp_value} = w;
                    exp_src = 1'b1;
                    m_last  = 1'b1;
                end else if (lsb_ok) begin
                    m_lsb.push_back({lsb_rob_entry_in, lsb_value_in});
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdy, input logic clr,
                                 input logic av, input logic [3:0] ae, input logic [31:0] aval,
                                 input logic lv, input logic [3:0] le, input logic [31:0] lval);
        rst_in = rst;  rdy_in = rdy;  clear_in = clr;
        alu_valid_in = av;  alu_rob_entry_in = ae;  alu_value_in = aval;
        lsb_valid_in = lv;  lsb_rob_entry_in = le;  lsb_value_in = lval;
        modelStep();
        @(posedge clk_in);
        #1;
        checkOutput("cdb_valid", 64'(cdb_valid_out), 64'(exp_valid));
        checkOutput("cdb_rob_entry", 64'(cdb_rob_entry_out), 64'(exp_rob));
        checkOutput("cdb_value", 64'(cdb_value_out), 64'(exp_value));
        checkOutput("cdb_src", 64'(cdb_src_out), 64'(exp_src));
        checkOutput("alu_stall", 64'(alu_stall_out), 64'(m_alu.size() == DEPTH));
        checkOutput("lsb_stall", 64'(lsb_stall_out), 64'(m_lsb.size() == DEPTH));
        if (lsb_stall_out) saw_lsb_stall = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 4'h5, 32'h55, 1, 4'h6, 32'h66);
    endtask

    initial begin
        saw_lsb_stall = 1'b0;
        doReset();
        checkOutput("reset_valid", 64'(cdb_valid_out), 64'd0);

        // Single ALU result after reset.
        applyStimulus(0, 1, 0, 1, 4'd3, 32'h11, 0, 0, 0);
        checkOutput("t1_valid", 64'(cdb_valid_out), 64'd1);
        checkOutput("t1_entry", 64'(cdb_rob_entry_out), 64'd3);
        checkOutput("t1_value", 64'(cdb_value_out), 64'h11);
        checkOutput("t1_src", 64'(cdb_src_out), 64'd0);
        idle(1);
        checkOutput("t1_idle_valid", 64'(cdb_valid_out), 64'd0);

        // Simultaneous tie right after reset.
        doReset();
        applyStimulus(0, 1, 0, 1, 4'd1, 32'hA, 1, 4'd2, 32'hB);
`ifdef CDB_LSB_PRIORITY_EN
        checkOutput("t2_first", 64'(cdb_value_out), 64'hB);
`else
        checkOutput("t2_first", 64'(cdb_value_out), 64'hA);
`endif
        idle(1);
`ifdef CDB_LSB_PRIORITY_EN
        checkOutput("t2_second", 64'(cdb_value_out), 64'hA);
`else
        checkOutput("t2_second", 64'(cdb_value_out), 64'hB);
`endif
        idle(1);

        // Both producers push every cycle they are allowed to.
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, 0, !alu_stall_out, 4'(i), 32'h100 + 32'(i),
                          !lsb_stall_out, 4'(i + 8), 32'h200 + 32'(i));
        end

        // Flush with the FIFOs loaded and a fresh ALU input present.
        applyStimulus(0, 1, 1, 1, 4'hE, 32'hDEAD, 0, 0, 0);
        checkOutput("t4_valid", 64'(cdb_valid_out), 64'd0);
        checkOutput("t4_alu_stall", 64'(alu_stall_out), 64'd0);
        checkOutput("t4_lsb_stall", 64'(lsb_stall_out), 64'd0);
        idle(3);
`ifndef CDB_LSB_PRIORITY_EN
        checkOutput("t3_lsb_stall_seen", 64'(saw_lsb_stall), 64'd1);
`endif

        // Freeze with two entries queued.
        doReset();
        applyStimulus(0, 1, 0, 1, 4'd1, 32'h21, 1, 4'd2, 32'h22);
        applyStimulus(0, 1, 0, 1, 4'd3, 32'h23, 1, 4'd4, 32'h24);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 4'hF, 32'hBAD, 1, 4'hF, 32'hBAD);
        end
        idle(3);

        // Reset while the bus is busy.
        applyStimulus(0, 1, 0, 1, 4'd5, 32'h31, 1, 4'd6, 32'h32);
        applyStimulus(0, 1, 0, 1, 4'd7, 32'h33, 1, 4'd8, 32'h34);
        applyStimulus(1, 1, 0, 1, 4'd9, 32'h35, 0, 0, 0);
        checkOutput("t6_valid", 64'(cdb_valid_out), 64'd0);
        checkOutput("t6_value", 64'(cdb_value_out), 64'd0);
        idle(2);

        // Random traffic, including occasional stall violations, freezes, flushes and resets.
        for (int i = 0; i < 600; i++) begin
            logic r_rst, r_rdy, r_clr, r_av, r_lv;
            r_rst = ($urandom_range(99) == 0);
            r_rdy = ($urandom_range(9) != 0);
            r_clr = ($urandom_range(39) == 0);
            r_av  = alu_stall_out ? ($urandom_range(9) == 0) : ($urandom_range(99) < 60);
            r_lv  = lsb_stall_out ? ($urandom_range(9) == 0) : ($urandom_range(99) < 60);
            applyStimulus(r_rst, r_rdy, r_clr, r_av, 4'($urandom), $urandom,
                          r_lv, 4'($urandom), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
